// File: rtl/mem_access_stage.sv
// Memory stage between execute and writeback: byte-lane loads/stores over a valid/ready request and response-valid port.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses issue no request and raise wb_misalign.
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic               flush,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [1:0]         mem_op,
  input  logic [2:0]         mem_sel,
  input  logic [1:0]         wb_sel_in,
  input  logic [RD_BITS-1:0] rd_in,
  input  logic               reg_we_in,
  input  logic [XLEN-1:0]    pc_adder_result_in,
  input  logic [XLEN-1:0]    pc_next_in,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic               dmem_req_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [3:0]         dmem_wstrb,
  input  logic               dmem_rsp_valid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               wb_valid,
  output logic [RD_BITS-1:0] wb_rd,
  output logic               wb_reg_we,
  output logic [1:0]         wb_sel,
  output logic [XLEN-1:0]    wb_alu_result,
  output logic [XLEN-1:0]    wb_pc_adder_result,
  output logic [XLEN-1:0]    wb_pc_next,
  output logic [XLEN-1:0]    wb_load_data,
  output logic               wb_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  state_t state, state_next;

  logic [XLEN-1:0]    cap_addr, cap_rs2, cap_pc_add, cap_pc_next;
  logic [1:0]         cap_op, cap_wb_sel;
  logic [2:0]         cap_sel;
  logic [RD_BITS-1:0] cap_rd;
  logic               cap_reg_we;
  logic               kill_q;

  logic accept, in_is_mem, misalign_in, kill, cap_store;
  logic [XLEN-1:0] sh_b, sh_h, load_ext;

  assign accept    = ex_valid && (state == IDLE) && !flush;
  assign in_is_mem = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
  assign kill      = kill_q || flush;
  assign cap_store = (cap_op == OP_STORE);

`ifdef MISALIGN_TRAP_EN
  // B/BU never misalign; H/HU need a[0]=0; W and reserved selects need a[1:0]=0.
  assign misalign_in = in_is_mem &&
    ((mem_sel[1:0] == 2'b01) ? alu_result[0] :
     (mem_sel[1:0] == 2'b00) ? 1'b0 : (alu_result[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_next     = state;
    ex_ready       = 1'b0;
    dmem_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (accept && in_is_mem && !misalign_in) state_next = REQ;
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_next = cap_store ? IDLE : WAIT;
      end
      WAIT: if (dmem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields come only from captured registers, so they stay stable while ready is low.
  always_comb begin
    dmem_addr   = {cap_addr[XLEN-1:2], 2'b00};
    dmem_req_we = dmem_req_valid && cap_store;
    dmem_wstrb  = 4'b0000;
    unique case (cap_sel[1:0])
      2'b00:   dmem_wdata = {4{cap_rs2[7:0]}};
      2'b01:   dmem_wdata = {2{cap_rs2[15:0]}};
      default: dmem_wdata = cap_rs2;
    endcase
    if (dmem_req_we) begin
      unique case (cap_sel[1:0])
        2'b00:   dmem_wstrb = 4'b0001 << cap_addr[1:0];
        2'b01:   dmem_wstrb = 4'b0011 << {cap_addr[1], 1'b0};
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

  assign sh_b = dmem_rdata >> {cap_addr[1:0], 3'b000};
  assign sh_h = dmem_rdata >> {cap_addr[1], 4'b0000};

  always_comb begin
    unique case (cap_sel)
      3'b000:  load_ext = {{(XLEN-8){sh_b[7]}}, sh_b[7:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, sh_b[7:0]};
      3'b001:  load_ext = {{(XLEN-16){sh_h[15]}}, sh_h[15:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, sh_h[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr <= '0; cap_rs2 <= '0; cap_pc_add <= '0; cap_pc_next <= '0;
      cap_op <= '0; cap_wb_sel <= '0; cap_sel <= '0; cap_rd <= '0;
      cap_reg_we <= 1'b0; kill_q <= 1'b0;
      wb_valid <= 1'b0; wb_rd <= '0; wb_reg_we <= 1'b0; wb_sel <= '0;
      wb_alu_result <= '0; wb_pc_adder_result <= '0; wb_pc_next <= '0;
      wb_load_data <= '0; wb_misalign <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        cap_addr <= alu_result; cap_rs2 <= rs2_data; cap_op <= mem_op;
        cap_sel <= mem_sel; cap_wb_sel <= wb_sel_in; cap_rd <= rd_in;
        cap_reg_we <= reg_we_in; cap_pc_add <= pc_adder_result_in;
        cap_pc_next <= pc_next_in; kill_q <= 1'b0;
        // Non-memory ops and trapped misaligned accesses write back straight from execute.
        if (!in_is_mem || misalign_in) begin
          wb_valid <= 1'b1; wb_rd <= rd_in; wb_reg_we <= reg_we_in && !misalign_in;
          wb_sel <= wb_sel_in; wb_alu_result <= alu_result;
          wb_pc_adder_result <= pc_adder_result_in; wb_pc_next <= pc_next_in;
          wb_load_data <= '0; wb_misalign <= misalign_in;
        end
      end
      if (state != IDLE && flush) kill_q <= 1'b1;
      if (((state == REQ && dmem_req_ready && cap_store) ||
           (state == WAIT && dmem_rsp_valid)) && !kill) begin
        wb_valid <= 1'b1; wb_rd <= cap_rd; wb_reg_we <= cap_reg_we;
        wb_sel <= cap_wb_sel; wb_alu_result <= cap_addr;
        wb_pc_adder_result <= cap_pc_add; wb_pc_next <= cap_pc_next;
        wb_load_data <= (state == WAIT) ? load_ext : '0;
        wb_misalign <= 1'b0;
      end
    end
  end

endmodule
